mul_share_arb: RTL and testbench

MUL_SHARE_ARB -- requirements
Module: mul_share_arb

---
 rtl/mul_share_arb_if.sv | 24 ++
 rtl/mul_share_arb.sv | 163 ++++++++++++++++
 tb/tb_mul_share_arb.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_arb_if.sv
// Request/response bundle between N_REQ requesters and the shared multiplier arbiter.
// master = requester side, slave = arbiter side.
interface mul_share_arb_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0][7:0] req_a;
  logic [N_REQ-1:0][7:0] req_b;
  logic [N_REQ-1:0]      req_ready;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [15:0]           resp_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin issue of 8x8 multiplies from N_REQ requesters into one 3-stage pipe; result is registered 4 edges after grant.
// Only issue can stall (hold); the pipe and the response never stall.
module mul_share_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_share_arb_if.slave bus,
  input  logic           hold,
  output logic [1:0]     inflight,
  output logic           idle
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_HELD} state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [7:0]      a;
    logic [7:0]      b;
  } s1_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [7:0]      pp_ll;
    logic [7:0]      pp_lh;
    logic [7:0]      pp_hl;
    logic [7:0]      pp_hh;
  } s2_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     prod;
  } s3_t;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             s1_vld_q, s1_vld_d;
  logic             s2_vld_q, s2_vld_d;
  logic             s3_vld_q, s3_vld_d;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  s3_t              s3_q, s3_d;
  logic [1:0]       inflight_q, inflight_d;
  logic             resp_vld_q, resp_vld_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [15:0]      resp_dat_q, resp_dat_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_vld;
  logic             req_any;

  assign req_any = |bus.req_valid;

  // Circular search from ptr; reset gates the grant so req_ready drops without a clock.
  always_comb begin : arb_c
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
    if (hold || !rst_n) begin
      grant_vld = 1'b0;
    end
    grant = grant_vld ? (N_REQ'(1) << grant_id) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_comb begin
    if (hold && req_any) begin
      state_d = ST_HELD;
    end else if (grant_vld) begin
      state_d = ST_ISSUE;
    end else if (inflight_q != 2'd0) begin
      state_d = ST_DRAIN;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    s1_vld_d = grant_vld;
    s1_d.id  = grant_id;
    s1_d.a   = bus.req_a[grant_id];
    s1_d.b   = bus.req_b[grant_id];

    s2_vld_d    = s1_vld_q;
    s2_d.id     = s1_q.id;
    s2_d.pp_ll  = {4'h0, s1_q.a[3:0]} * {4'h0, s1_q.b[3:0]};
    s2_d.pp_lh  = {4'h0, s1_q.a[3:0]} * {4'h0, s1_q.b[7:4]};
    s2_d.pp_hl  = {4'h0, s1_q.a[7:4]} * {4'h0, s1_q.b[3:0]};
    s2_d.pp_hh  = {4'h0, s1_q.a[7:4]} * {4'h0, s1_q.b[7:4]};

    // Exact 16-bit sum: the total never exceeds 255*255.
    s3_vld_d  = s2_vld_q;
    s3_d.id   = s2_q.id;
    s3_d.prod = {s2_q.pp_hh, 8'h00}
              + {4'h0, s2_q.pp_lh, 4'h0}
              + {4'h0, s2_q.pp_hl, 4'h0}
              + {8'h00, s2_q.pp_ll};

    resp_vld_d = s3_vld_q;
    resp_id_d  = s3_vld_q ? s3_q.id   : '0;
    resp_dat_d = s3_vld_q ? s3_q.prod : '0;

    inflight_d = {1'b0, s1_vld_d} + {1'b0, s2_vld_d} + {1'b0, s3_vld_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s3_vld_q   <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      inflight_q <= 2'd0;
      resp_vld_q <= 1'b0;
      resp_id_q  <= '0;
      resp_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      s3_vld_q   <= s3_vld_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      inflight_q <= inflight_d;
      resp_vld_q <= resp_vld_d;
      resp_id_q  <= resp_id_d;
      resp_dat_q <= resp_dat_d;
    end
  end

  // An issue cycle always leaves S1 occupied.
  a_issue_fills_s1: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_ISSUE) |-> s1_vld_q);

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_vld_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_dat_q;
  assign inflight       = inflight_q;
  assign idle           = (inflight_q == 2'd0) && !req_any;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb: arbitration order, latency, data, hold and async reset.
module tb_mul_share_arb;
  logic       clk;
  logic       rst_n;
  logic       hold;
  logic [1:0] inflight;
  logic       idle;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  a_tab    [4] = '{8'd3, 8'd7, 8'd100, 8'd171};
  logic [7:0]  b_tab    [4] = '{8'd5, 8'd9, 8'd200, 8'd205};
  logic [15:0] prod_tab [4] = '{16'd15, 16'd63, 16'd20000, 16'd35055};

  mul_share_arb_if #(.N_REQ(4), .ID_W(2)) bus ();

  mul_share_arb #(.N_REQ(4), .ID_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .hold     (hold),
    .inflight (inflight),
    .idle     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops();
    for (int k = 0; k < 4; k++) begin
      bus.req_a[k] = a_tab[k];
      bus.req_b[k] = b_tab[k];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int exp_if;
    rst_n         = 1'b0;
    hold          = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // Reset state, checked before any clock edge
    #3;
    bus.req_valid = 4'hF;
    #1;
    chk("rst_rdy", bus.req_ready, 0);
    chk("rst_rvld", bus.resp_valid, 0);
    chk("rst_rid", bus.resp_id, 0);
    chk("rst_rdat", bus.resp_data, 0);
    chk("rst_infl", inflight, 0);
    bus.req_valid = '0;
    #1;
    chk("rst_idle", idle, 1);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", idle, 1);

    // Single op from requester 2
    bus.req_a[2]  = 8'd13;
    bus.req_b[2]  = 8'd11;
    bus.req_valid = 4'b0100;
    #1;
    chk("op1_rdy", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = '0;
    chk("op1_e0_infl", inflight, 1);
    chk("op1_e0_rvld", bus.resp_valid, 0);
    step();
    chk("op1_e1_infl", inflight, 1);
    chk("op1_e1_rvld", bus.resp_valid, 0);
    step();
    chk("op1_e2_infl", inflight, 1);
    chk("op1_e2_rvld", bus.resp_valid, 0);
    step();
    chk("op1_e3_rvld", bus.resp_valid, 1);
    chk("op1_e3_rid", bus.resp_id, 2);
    chk("op1_e3_rdat", bus.resp_data, 143);
    chk("op1_e3_infl", inflight, 0);
    step();
    chk("op1_e4_rvld", bus.resp_valid, 0);
    chk("op1_e4_rid", bus.resp_id, 0);
    chk("op1_e4_rdat", bus.resp_data, 0);
    chk("op1_e4_idle", idle, 1);

    // Extremes, back-to-back from requester 3 (ptr is 3 here)
    bus.req_a[3]  = 8'hFF;
    bus.req_b[3]  = 8'hFF;
    bus.req_valid = 4'b1000;
    #1;
    chk("ext_rdy0", bus.req_ready, 4'b1000);
    step();
    bus.req_a[3] = 8'h00;
    #1;
    chk("ext_rdy1", bus.req_ready, 4'b1000);
    step();
    bus.req_valid = '0;
    chk("ext_infl1", inflight, 2);
    step();
    chk("ext_infl2", inflight, 2);
    step();
    chk("ext_ff_rvld", bus.resp_valid, 1);
    chk("ext_ff_rid", bus.resp_id, 3);
    chk("ext_ff_rdat", bus.resp_data, 16'hFE01);
    step();
    chk("ext_zero_rvld", bus.resp_valid, 1);
    chk("ext_zero_rid", bus.resp_id, 3);
    chk("ext_zero_rdat", bus.resp_data, 16'h0000);
    step();
    chk("ext_end_rvld", bus.resp_valid, 0);

    // Contention: all four valid from ptr 0, 8 grants
    load_ops();
    bus.req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      if (c == 8) bus.req_valid = '0;
      #1;
      chk("rr_rdy", bus.req_ready, (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
      step();
      if (c >= 3 && c <= 10) begin
        chk("rr_rvld", bus.resp_valid, 1);
        chk("rr_rid", bus.resp_id, (c - 3) % 4);
        chk("rr_rdat", bus.resp_data, prod_tab[(c - 3) % 4]);
      end else begin
        chk("rr_rvld", bus.resp_valid, 0);
        chk("rr_rdat", bus.resp_data, 0);
      end
      exp_if = 0;
      for (int k = c - 2; k <= c; k++) if (k >= 0 && k <= 7) exp_if++;
      chk("rr_infl", inflight, exp_if);
    end

    // Hold for 5 cycles with 3 ops in flight and requests pending
    bus.req_valid = 4'hF;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) hold = 1'b1;
      if (c == 8) hold = 1'b0;
      if (c == 9) bus.req_valid = '0;
      #1;
      if (c < 3)       chk("hold_rdy", bus.req_ready, 32'd1 << c);
      else if (c == 8) chk("hold_resume_rdy", bus.req_ready, 4'b1000);
      else             chk("hold_rdy", bus.req_ready, 0);
      step();
      if (c >= 3 && c <= 5) begin
        chk("hold_rvld", bus.resp_valid, 1);
        chk("hold_rid", bus.resp_id, c - 3);
        chk("hold_rdat", bus.resp_data, prod_tab[c - 3]);
      end else if (c == 11) begin
        chk("hold_rvld", bus.resp_valid, 1);
        chk("hold_rid", bus.resp_id, 3);
        chk("hold_rdat", bus.resp_data, prod_tab[3]);
      end else begin
        chk("hold_rvld", bus.resp_valid, 0);
      end
      if (c == 7) begin
        chk("hold_infl", inflight, 0);
        chk("hold_idle", idle, 0);
      end
    end
    chk("hold_end_idle", idle, 1);

    // Reset mid-flight with ptr moved away from 0
    bus.req_valid = 4'b0111;
    repeat (4) step();
    chk("mid_rvld", bus.resp_valid, 1);
    chk("mid_rdat", bus.resp_data, prod_tab[0]);
    chk("mid_infl", inflight, 3);
    bus.req_valid = 4'b1001;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rdy", bus.req_ready, 0);
    chk("async_rvld", bus.resp_valid, 0);
    chk("async_rid", bus.resp_id, 0);
    chk("async_rdat", bus.resp_data, 0);
    chk("async_infl", inflight, 0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      chk("rel_no_rvld", bus.resp_valid, 0);
      step();
    end
    chk("rel_rvld", bus.resp_valid, 1);
    chk("rel_rid", bus.resp_id, 0);
    chk("rel_rdat", bus.resp_data, prod_tab[0]);

    // Fairness: requester 0 continuous, requester 3 asserts once
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) bus.req_valid = 4'b1001;
      if (c == 3) bus.req_valid = 4'b0001;
      #1;
      chk("fair_rdy", bus.req_ready, (c == 2) ? 32'd8 : 32'd1);
      step();
      if (c >= 3) begin
        chk("fair_rid", bus.resp_id, (c == 5) ? 3 : 0);
        chk("fair_rdat", bus.resp_data, (c == 5) ? prod_tab[3] : prod_tab[0]);
      end
    end
    bus.req_valid = '0;
    repeat (5) step();
    chk("final_idle", idle, 1);
    chk("final_infl", inflight, 0);
    chk("final_rvld", bus.resp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
